// File: rtl/hazard_sched.sv
// Pipeline interlock and scheduling controller for the 5-stage core.
// Tracks E/M/W destinations in a shadow scoreboard and drives stalls,
// bubbles, flushes, E-stage forwarding selects and perf counters.
//
// Ports:
//   clk, reset              core clock, synchronous active-high reset
//   d_valid, d_rs_a, d_rt_a,
//   d_rd_a, d_uses_rs,
//   d_uses_rt, d_is_load,
//   d_is_jump               decode-stage instruction description
//   e_br_taken              BEQ in E resolved taken this cycle
//   m_mem_busy              data memory not ready, M cannot complete
//   stall_f, stall_d,
//   stall_em                hold PC / F-D / D-E, E-M, M-W registers
//   bubble_e                load NOP into D/E
//   flush_f, flush_d        squash fetch / decode instruction
//   fwd_rs_sel, fwd_rt_sel  E operand source: 0 D, 1 M result, 2 W result
//   stall_cnt, flush_cnt    saturating stall_f / flush_d cycle counters
module hazard_sched #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs_a,
    input  logic [REG_W-1:0] d_rt_a,
    input  logic [REG_W-1:0] d_rd_a,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic             d_is_load,
    input  logic             d_is_jump,
    input  logic             e_br_taken,
    input  logic             m_mem_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_em,
    output logic             bubble_e,
    output logic             flush_f,
    output logic             flush_d,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] LU_STALL = 2'd1;
    localparam logic [1:0] MEM_HOLD = 2'd2;

    logic [1:0]       state_q, state_d;

    logic             e_vld_q;
    logic [REG_W-1:0] e_dst_q;
    logic             e_ld_q;
    logic [REG_W-1:0] e_rs_q;
    logic [REG_W-1:0] e_rt_q;
    logic             m_vld_q;
    logic [REG_W-1:0] m_dst_q;
    logic             w_vld_q;
    logic [REG_W-1:0] w_dst_q;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             lu_haz;
    logic             sf_c, sd_c, sem_c, be_c, ff_c, fd_c;
    logic [1:0]       rs_sel_c, rt_sel_c;

    // Load in E whose (non-R0) destination is read by the instruction in D.
    assign lu_haz = e_vld_q && e_ld_q && (e_dst_q != '0) && d_valid &&
                    ((d_uses_rs && (d_rs_a == e_dst_q)) ||
                     (d_uses_rt && (d_rt_a == e_dst_q)));

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != '0) begin
            if (m_vld_q && (m_dst_q == src))
                sel = 2'd1;
            else if (w_vld_q && (w_dst_q == src))
                sel = 2'd2;
        end
        return sel;
    endfunction

    // MEM_HOLD with busy deasserted behaves like RUN: the frozen branch or
    // load-use is re-evaluated in the same cycle the memory completes.
    always_comb begin
        sf_c    = 1'b0;
        sd_c    = 1'b0;
        sem_c   = 1'b0;
        be_c    = 1'b0;
        ff_c    = 1'b0;
        fd_c    = 1'b0;
        state_d = RUN;
        if (m_mem_busy) begin
            sf_c    = 1'b1;
            sd_c    = 1'b1;
            sem_c   = 1'b1;
            state_d = MEM_HOLD;
        end else if (state_q == LU_STALL) begin
            state_d = RUN;
        end else if (e_br_taken) begin
            ff_c = 1'b1;
            fd_c = 1'b1;
            be_c = 1'b1;
        end else if (lu_haz) begin
            sf_c    = 1'b1;
            sd_c    = 1'b1;
            be_c    = 1'b1;
            state_d = LU_STALL;
        end else if (d_valid && d_is_jump) begin
            ff_c = 1'b1;
        end
    end

    assign rs_sel_c = fwd_sel(e_rs_q);
    assign rt_sel_c = fwd_sel(e_rt_q);

    // Everything is forced quiet while reset is being sampled.
    assign stall_f    = sf_c  & ~reset;
    assign stall_d    = sd_c  & ~reset;
    assign stall_em   = sem_c & ~reset;
    assign bubble_e   = be_c  & ~reset;
    assign flush_f    = ff_c  & ~reset;
    assign flush_d    = fd_c  & ~reset;
    assign fwd_rs_sel = reset ? 2'd0 : rs_sel_c;
    assign fwd_rt_sel = reset ? 2'd0 : rt_sel_c;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            e_vld_q     <= 1'b0;
            e_dst_q     <= '0;
            e_ld_q      <= 1'b0;
            e_rs_q      <= '0;
            e_rt_q      <= '0;
            m_vld_q     <= 1'b0;
            m_dst_q     <= '0;
            w_vld_q     <= 1'b0;
            w_dst_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (!sem_c) begin
                w_vld_q <= m_vld_q;
                w_dst_q <= m_dst_q;
                m_vld_q <= e_vld_q;
                m_dst_q <= e_dst_q;
                if (be_c) begin
                    e_vld_q <= 1'b0;
                    e_dst_q <= '0;
                    e_ld_q  <= 1'b0;
                    e_rs_q  <= '0;
                    e_rt_q  <= '0;
                end else begin
                    e_vld_q <= d_valid;
                    e_dst_q <= d_rd_a;
                    e_ld_q  <= d_is_load;
                    e_rs_q  <= d_rs_a;
                    e_rt_q  <= d_rt_a;
                end
            end
            if (sf_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (fd_c && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios plus random
// traffic compared against a slot-based behavioural model.
module tb_hazard_sched;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          d_valid;
    logic [4:0]    d_rs_a, d_rt_a, d_rd_a;
    logic          d_uses_rs, d_uses_rt, d_is_load, d_is_jump;
    logic          e_br_taken, m_mem_busy;
    logic          stall_f, stall_d, stall_em, bubble_e, flush_f, flush_d;
    logic [1:0]    fwd_rs_sel, fwd_rt_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_sched #(.REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_rs_a(d_rs_a), .d_rt_a(d_rt_a),
        .d_rd_a(d_rd_a), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .d_is_load(d_is_load), .d_is_jump(d_is_jump),
        .e_br_taken(e_br_taken), .m_mem_busy(m_mem_busy),
        .stall_f(stall_f), .stall_d(stall_d), .stall_em(stall_em),
        .bubble_e(bubble_e), .flush_f(flush_f), .flush_d(flush_d),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one slot per downstream stage plus a flag meaning
    // "last cycle inserted a load-use bubble".
    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       ld;
        logic [4:0] rs;
        logic [4:0] rt;
    } slot_t;

    slot_t me, mm, mw;
    bit    mlu;
    int    mscnt, mfcnt;
    bit    x_sf, x_sd, x_sem, x_be, x_ff, x_fd, x_luh;
    logic [1:0] x_rs, x_rt;

    function automatic logic [1:0] mfwd(input logic [4:0] s);
        if (s == 5'd0) return 2'd0;
        if (mm.v && mm.dst == s) return 2'd1;
        if (mw.v && mw.dst == s) return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        {x_sf, x_sd, x_sem, x_be, x_ff, x_fd, x_luh} = '0;
        x_rs = 2'd0;
        x_rt = 2'd0;
        if (!reset) begin
            x_luh = me.v && me.ld && me.dst != 0 && d_valid &&
                    ((d_uses_rs && d_rs_a == me.dst) ||
                     (d_uses_rt && d_rt_a == me.dst));
            if (m_mem_busy) begin
                x_sf = 1; x_sd = 1; x_sem = 1;
            end else if (mlu) begin
                // bubble cycle: nothing to do
            end else if (e_br_taken) begin
                x_ff = 1; x_fd = 1; x_be = 1;
            end else if (x_luh) begin
                x_sf = 1; x_sd = 1; x_be = 1;
            end else if (d_valid && d_is_jump) begin
                x_ff = 1;
            end
            x_rs = mfwd(me.rs);
            x_rt = mfwd(me.rt);
        end
    endtask

    task automatic model_update();
        bit nlu;
        if (reset) begin
            me = '0; mm = '0; mw = '0;
            mlu = 0; mscnt = 0; mfcnt = 0;
        end else begin
            nlu = !m_mem_busy && !mlu && !e_br_taken && x_luh;
            if (x_sf && mscnt < CMAX) mscnt++;
            if (x_fd && mfcnt < CMAX) mfcnt++;
            if (!x_sem) begin
                mw = mm;
                mm = me;
                if (x_be) me = '0;
                else me = {d_valid, d_rd_a, d_is_load, d_rs_a, d_rt_a};
            end
            mlu = nlu;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("stall_f", stall_f, x_sf);
        chk("stall_d", stall_d, x_sd);
        chk("stall_em", stall_em, x_sem);
        chk("bubble_e", bubble_e, x_be);
        chk("flush_f", flush_f, x_ff);
        chk("flush_d", flush_d, x_fd);
        chk("fwd_rs_sel", fwd_rs_sel, x_rs);
        chk("fwd_rt_sel", fwd_rt_sel, x_rt);
        chk("stall_cnt", stall_cnt, mscnt);
        chk("flush_cnt", flush_cnt, mfcnt);
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic set_d(input bit v, input int rs, input int rt,
                         input int rd, input bit urs, input bit urt,
                         input bit ld, input bit jmp);
        d_valid   = v;
        d_rs_a    = 5'(rs);
        d_rt_a    = 5'(rt);
        d_rd_a    = 5'(rd);
        d_uses_rs = urs;
        d_uses_rt = urt;
        d_is_load = ld;
        d_is_jump = jmp;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1; nop(); e_br_taken = 0; m_mem_busy = 0;
        tick(); tick();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        nop();
        e_br_taken = 0;
        m_mem_busy = 0;
        me = '0; mm = '0; mw = '0; mlu = 0; mscnt = 0; mfcnt = 0;
        @(posedge clk); #1;
        do_reset();

        // Load-use with W forward afterwards
        set_d(1, 1, 0, 2, 1, 0, 1, 0); tick();
        set_d(1, 2, 1, 3, 1, 1, 0, 0); settle();
        chk("t1_stall", stall_f, 1); chk("t1_bubble", bubble_e, 1); adv();
        settle(); chk("t1_nostall", stall_f, 0); adv();
        nop(); settle(); chk("t1_fwd_rs", fwd_rs_sel, 2); adv();

        // ALU producer feeding a store: M forward
        set_d(1, 0, 0, 4, 1, 0, 0, 0); tick();
        set_d(1, 5, 4, 0, 1, 1, 0, 0); settle();
        chk("t2_nostall", stall_f, 0); adv();
        nop(); settle(); chk("t2_fwd_rt", fwd_rt_sel, 1); adv();

        // Taken branch overrides load-use
        do_reset();
        set_d(1, 1, 0, 2, 1, 0, 1, 0); tick();
        set_d(1, 2, 1, 3, 1, 1, 0, 0); e_br_taken = 1; settle();
        chk("t3_flush_d", flush_d, 1); chk("t3_stall", stall_f, 0);
        chk("t3_cnt0", flush_cnt, 0); adv();
        e_br_taken = 0; nop(); settle();
        chk("t3_cnt1", flush_cnt, 1); chk("t3_nolu", stall_f, 0); adv();

        // Memory busy during a load-use
        do_reset();
        set_d(1, 1, 0, 2, 1, 0, 1, 0); tick();
        set_d(1, 2, 1, 3, 1, 1, 0, 0); m_mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("t4_stall_em", stall_em, 1); adv();
        end
        m_mem_busy = 0; settle();
        chk("t4_lu", bubble_e, 1); chk("t4_em", stall_em, 0); adv();
        settle(); chk("t4_cnt", stall_cnt, 4); chk("t4_once", stall_f, 0);
        adv();

        // R0 is never a hazard
        do_reset();
        set_d(1, 1, 0, 0, 1, 0, 1, 0); tick();
        set_d(1, 0, 0, 3, 1, 1, 0, 0); settle();
        chk("t5_nostall", stall_f, 0); adv();
        nop(); settle();
        chk("t5_rs", fwd_rs_sel, 0); chk("t5_rt", fwd_rt_sel, 0); adv();

        // Reset while in the load-use bubble
        do_reset();
        set_d(1, 1, 0, 2, 1, 0, 1, 0); tick();
        set_d(1, 2, 1, 3, 1, 1, 0, 0); tick();
        reset = 1; settle();
        chk("t6_quiet", stall_f, 0); chk("t6_cnt_pre", stall_cnt, 1); adv();
        reset = 0; settle();
        chk("t6_cnt", stall_cnt, 0); chk("t6_nostall", stall_f, 0); adv();
        set_d(1, 1, 0, 2, 1, 0, 1, 0); tick();
        set_d(1, 2, 1, 3, 1, 1, 0, 0); settle();
        chk("t6_run_lu", stall_f, 1); adv();

        // Counter saturation
        do_reset();
        m_mem_busy = 1;
        repeat (CMAX + 4) tick();
        m_mem_busy = 0; nop(); settle();
        chk("sat_stall", stall_cnt, CMAX); adv();
        e_br_taken = 1;
        repeat (CMAX + 4) tick();
        e_br_taken = 0; settle();
        chk("sat_flush", flush_cnt, CMAX); adv();

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom % 150) == 0;
            d_valid    = ($urandom % 8) != 0;
            d_rs_a     = 5'($urandom % 4);
            d_rt_a     = 5'($urandom % 4);
            d_rd_a     = 5'($urandom % 4);
            d_uses_rs  = $urandom % 2;
            d_uses_rt  = $urandom % 2;
            d_is_load  = ($urandom % 3) == 0;
            d_is_jump  = !d_is_load && (($urandom % 8) == 0);
            e_br_taken = ($urandom % 10) == 0;
            m_mem_busy = ($urandom % 7) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
